// File: rtl/dmem_unit.sv
// Multi-cycle single-port data memory for the MEM stage. A load or store takes
// LATENCY cycles, during which stall holds the pipeline; results land in a one-cycle DONE state.
module dmem_unit #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        addr_err,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
    localparam bit         SINGLE   = (LATENCY == 1);

    state_t              state;
    logic [2:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wr_data_q;
    logic                is_wr;
    logic                oor;

    logic [15:0]         mem [2**ADDR_W];

    logic                req;
    logic                in_oor;
    logic                acc_now;
    logic [ADDR_W-1:0]   acc_idx;
    logic [15:0]         acc_data;
    logic                acc_wr;
    logic                acc_oor;

    assign req    = MemRead_in | MemWrite_in;
    assign in_oor = |addr[15:ADDR_W];

    // With LATENCY==1 the access happens at the accepting edge, so it must use
    // the live inputs; otherwise it uses the values captured in IDLE.
    always_comb begin
        acc_now  = 1'b0;
        acc_idx  = addr_q;
        acc_data = wr_data_q;
        acc_wr   = is_wr;
        acc_oor  = oor;
        if (state == IDLE) begin
            acc_now  = SINGLE && req;
            acc_idx  = addr[ADDR_W-1:0];
            acc_data = wr_data;
            acc_wr   = MemWrite_in;
            acc_oor  = in_oor;
        end else if (state == BUSY) begin
            acc_now  = (cnt == 3'd1);
        end
    end

    // Gated by rst so an access cannot complete while reset is held.
    assign stall = rst && (((state == IDLE) && req) || (state == BUSY));

    always_ff @(posedge clk) begin
        if (rst && acc_now && acc_wr && !acc_oor)
            mem[acc_idx] <= acc_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            addr_q    <= '0;
            wr_data_q <= 16'h0000;
            is_wr     <= 1'b0;
            oor       <= 1'b0;
            rd_data   <= 16'h0000;
            rd_valid  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            if (acc_now) begin
                rd_valid <= !acc_wr;
                addr_err <= acc_oor;
                if (!acc_wr)
                    rd_data <= acc_oor ? 16'h0000 : mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q    <= addr[ADDR_W-1:0];
                        wr_data_q <= wr_data;
                        is_wr     <= MemWrite_in;
                        oor       <= in_oor;
                        if (SINGLE) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 3'd1)
                        state <= DONE;
                    else
                        cnt <= cnt - 3'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: a LATENCY=3 instance for most scenarios and a
// LATENCY=1 instance for the single-cycle case.
module tb_dmem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mr, mw;
    logic [15:0] a, d;
    logic [15:0] rd_data;
    logic        rd_valid, addr_err, stall;

    logic        mr1, mw1;
    logic [15:0] a1, d1;
    logic [15:0] rd_data1;
    logic        rd_valid1, addr_err1, stall1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_unit #(.ADDR_W(8), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .MemRead_in(mr), .MemWrite_in(mw),
        .addr(a), .wr_data(d), .rd_data(rd_data), .rd_valid(rd_valid),
        .addr_err(addr_err), .stall(stall)
    );

    dmem_unit #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .MemRead_in(mr1), .MemWrite_in(mw1),
        .addr(a1), .wr_data(d1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .addr_err(addr_err1), .stall(stall1)
    );

    // Presents a request at posedge+1, counts stalled cycles, samples DONE,
    // holds the request through DONE, then drops it at the next posedge+1.
    task automatic access(input logic r, input logic w, input logic [15:0] ai, input logic [15:0] di,
                          output int nstall, output int done_cyc, output logic [15:0] rdat,
                          output logic rv, output logic ae, output logic early_rv);
        mr = r; mw = w; a = ai; d = di;
        nstall = 0; early_rv = 1'b0;
        #1;
        while (stall && nstall < 20) begin
            nstall++;
            if (rd_valid) early_rv = 1'b1;
            @(posedge clk); #2;
        end
        done_cyc = cyc; rdat = rd_data; rv = rd_valid; ae = addr_err;
        @(posedge clk); #1;
        mr = 1'b0; mw = 1'b0;
    endtask

    task automatic access1(input logic r, input logic w, input logic [15:0] ai, input logic [15:0] di,
                           output int nstall, output logic [15:0] rdat, output logic rv);
        mr1 = r; mw1 = w; a1 = ai; d1 = di;
        nstall = 0;
        #1;
        while (stall1 && nstall < 20) begin
            nstall++;
            @(posedge clk); #2;
        end
        rdat = rd_data1; rv = rd_valid1;
        @(posedge clk); #1;
        mr1 = 1'b0; mw1 = 1'b0;
    endtask

    task automatic test_reset();
        mr = 1'b1; mw = 1'b0; a = 16'h0012; d = 16'h0000;
        mr1 = 1'b1; mw1 = 1'b0; a1 = 16'h0003; d1 = 16'h0000;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        total++; if (rd_valid !== 1'b0 || addr_err !== 1'b0) begin bad++; $display("FAIL reset_flags: got rv=%b ae=%b want 0 0", rd_valid, addr_err); end
        total++; if (stall1 !== 1'b0 || rd_valid1 !== 1'b0) begin bad++; $display("FAIL reset_lat1: got stall=%b rv=%b want 0 0", stall1, rd_valid1); end
        mr = 1'b0; mr1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #2;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_idle_stall: got %b want 0", stall); end
        #(-1+1);
    endtask

    task automatic test_store_load();
        int ns, dc; logic [15:0] rdat; logic rv, ae, erv;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 16'h0012, 16'hBEEF, ns, dc, rdat, rv, ae, erv);
        total++; if (ns !== 3) begin bad++; $display("FAIL st_stall_cycles: got %0d want 3", ns); end
        total++; if (rv !== 1'b0 || erv !== 1'b0) begin bad++; $display("FAIL st_rd_valid: got done=%b early=%b want 0 0", rv, erv); end
        total++; if (rdat !== 16'h0000) begin bad++; $display("FAIL st_rd_data_hold: got %h want 0000", rdat); end
        access(1'b1, 1'b0, 16'h0012, 16'h0000, ns, dc, rdat, rv, ae, erv);
        total++; if (ns !== 3) begin bad++; $display("FAIL ld_stall_cycles: got %0d want 3", ns); end
        total++; if (rdat !== 16'hBEEF) begin bad++; $display("FAIL ld_rd_data: got %h want beef", rdat); end
        total++; if (rv !== 1'b1 || ae !== 1'b0 || erv !== 1'b0) begin bad++; $display("FAIL ld_flags: got rv=%b ae=%b early=%b want 1 0 0", rv, ae, erv); end
    endtask

    task automatic test_back_to_back();
        int ns, dc1, dc2; logic [15:0] r1, r2; logic rv, ae, erv; logic extra;
        access(1'b0, 1'b1, 16'h0001, 16'h1111, ns, dc1, r1, rv, ae, erv);
        access(1'b0, 1'b1, 16'h0002, 16'h2222, ns, dc1, r1, rv, ae, erv);
        access(1'b1, 1'b0, 16'h0001, 16'h0000, ns, dc1, r1, rv, ae, erv);
        access(1'b1, 1'b0, 16'h0002, 16'h0000, ns, dc2, r2, rv, ae, erv);
        total++; if (dc2 - dc1 !== 4) begin bad++; $display("FAIL b2b_spacing: got %0d want 4", dc2 - dc1); end
        total++; if (r1 !== 16'h1111) begin bad++; $display("FAIL b2b_first: got %h want 1111", r1); end
        total++; if (r2 !== 16'h2222) begin bad++; $display("FAIL b2b_second: got %h want 2222", r2); end
        extra = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (stall || rd_valid) extra = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (extra !== 1'b0) begin bad++; $display("FAIL b2b_no_third: got %b want 0", extra); end
    endtask

    task automatic test_both_high();
        int ns, dc; logic [15:0] rdat; logic rv, ae, erv;
        access(1'b1, 1'b1, 16'h0005, 16'h00A5, ns, dc, rdat, rv, ae, erv);
        total++; if (rv !== 1'b0 || rdat !== 16'h2222) begin bad++; $display("FAIL both_is_store: got rv=%b rd=%h want 0 2222", rv, rdat); end
        access(1'b1, 1'b0, 16'h0005, 16'h0000, ns, dc, rdat, rv, ae, erv);
        total++; if (rdat !== 16'h00A5 || rv !== 1'b1) begin bad++; $display("FAIL both_readback: got %h rv=%b want 00a5 1", rdat, rv); end
    endtask

    task automatic test_oor();
        int ns, dc; logic [15:0] rdat; logic rv, ae, erv;
        access(1'b0, 1'b1, 16'h0105, 16'h1234, ns, dc, rdat, rv, ae, erv);
        total++; if (ae !== 1'b1 || rv !== 1'b0) begin bad++; $display("FAIL oor_store_err: got ae=%b rv=%b want 1 0", ae, rv); end
        access(1'b1, 1'b0, 16'h0005, 16'h0000, ns, dc, rdat, rv, ae, erv);
        total++; if (rdat !== 16'h00A5 || ae !== 1'b0) begin bad++; $display("FAIL oor_no_alias: got %h ae=%b want 00a5 0", rdat, ae); end
        access(1'b1, 1'b0, 16'h0105, 16'h0000, ns, dc, rdat, rv, ae, erv);
        total++; if (rdat !== 16'h0000 || ae !== 1'b1 || rv !== 1'b1) begin bad++; $display("FAIL oor_load: got %h ae=%b rv=%b want 0000 1 1", rdat, ae, rv); end
    endtask

    task automatic test_reset_mid_store();
        int ns, dc; logic [15:0] rdat; logic rv, ae, erv;
        access(1'b0, 1'b1, 16'h0007, 16'h0000, ns, dc, rdat, rv, ae, erv);
        access(1'b1, 1'b0, 16'h0005, 16'h0000, ns, dc, rdat, rv, ae, erv);
        mr = 1'b0; mw = 1'b1; a = 16'h0007; d = 16'hDEAD;
        @(posedge clk); #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_mid_busy: got stall=%b want 1", stall); end
        rst = 1'b0;
        #1;
        total++; if (stall !== 1'b0 || rd_data !== 16'h0000 || rd_valid !== 1'b0 || addr_err !== 1'b0) begin
            bad++; $display("FAIL rst_mid_clear: got stall=%b rd=%h rv=%b ae=%b want 0 0000 0 0", stall, rd_data, rd_valid, addr_err);
        end
        repeat (3) @(posedge clk);
        #1;
        mw = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 16'h0007, 16'h0000, ns, dc, rdat, rv, ae, erv);
        total++; if (rdat !== 16'h0000 || rv !== 1'b1 || ns !== 3) begin bad++; $display("FAIL rst_mid_no_write: got %h rv=%b stalls=%0d want 0000 1 3", rdat, rv, ns); end
    endtask

    task automatic test_latency1();
        int ns; logic [15:0] rdat; logic rv;
        access1(1'b0, 1'b1, 16'h0003, 16'h3333, ns, rdat, rv);
        total++; if (ns !== 1 || rv !== 1'b0) begin bad++; $display("FAIL lat1_store: got stalls=%0d rv=%b want 1 0", ns, rv); end
        access1(1'b1, 1'b0, 16'h0003, 16'h0000, ns, rdat, rv);
        total++; if (ns !== 1) begin bad++; $display("FAIL lat1_stall: got %0d want 1", ns); end
        total++; if (rdat !== 16'h3333 || rv !== 1'b1) begin bad++; $display("FAIL lat1_load: got %h rv=%b want 3333 1", rdat, rv); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mr = 1'b0; mw = 1'b0; a = 16'h0000; d = 16'h0000;
        mr1 = 1'b0; mw1 = 1'b0; a1 = 16'h0000; d1 = 16'h0000;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_both_high();
        test_oor();
        test_reset_mid_store();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
